// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared SRAM control bit indices, FSM states and defaults
// Optional feature macro (see rr arbiter): SRAM_ARB_FIXED_PRIO_EN
package sram_arbiter_pkg;
  localparam int CE_N = 4;
  localparam int OE_N = 3;
  localparam int WE_N = 2;
  localparam int UB_N = 1;
  localparam int LB_N = 0;
  localparam logic [4:0] CTRL_IDLE = 5'b11111;

  localparam int AW_DEF   = 18;
  localparam int DW_DEF   = 16;
  localparam int WAIT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Active-low control word driven for the whole ACCESS phase.
  function automatic logic [4:0] ctrl_access(input logic we, input logic [1:0] be);
    logic [4:0] c;
    c       = CTRL_IDLE;
    c[CE_N] = 1'b0;
    c[OE_N] = we;
    c[WE_N] = ~we;
    c[UB_N] = ~be[1];
    c[LB_N] = ~be[0];
    return c;
  endfunction
endpackage

// File: rtl/sram_arbiter_rr.sv
// rtl/sram_arbiter_rr.sv - 2-way grant logic for ports C and L
// SRAM_ARB_FIXED_PRIO_EN defined: port C always wins a contest, no pointer built.
module sram_arbiter_rr (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_c_req,
  input  logic i_l_req,
  input  logic i_update,
  output logic o_grant_c,
  output logic o_grant_l
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused  = i_clk ^ i_reset ^ i_update;
  assign o_grant_c = i_c_req;
  assign o_grant_l = i_l_req & ~i_c_req;
`else
  // Pointer only moves on contested grants so the loser wins the next contest.
  logic r_prio_l;
  assign o_grant_c = i_c_req & (~i_l_req | ~r_prio_l);
  assign o_grant_l = i_l_req & (~i_c_req | r_prio_l);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prio_l <= 1'b0;
    end else if (i_update && i_c_req && i_l_req) begin
      r_prio_l <= ~r_prio_l;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one async 256Kx16 SRAM between CPU (C) and logger (L) ports
// Macro SRAM_ARB_FIXED_PRIO_EN selects fixed C priority instead of round robin.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_CYCLES = WAIT_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  input  logic [1:0]    i_c_be,
  output logic [DW-1:0] o_c_rdata,
  output logic          o_c_ack,
  input  logic          i_l_req,
  input  logic          i_l_we,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  input  logic [1:0]    i_l_be,
  output logic [DW-1:0] o_l_rdata,
  output logic          o_l_ack,
  output logic [AW-1:0] o_sram_addr,
  inout  wire  [DW-1:0] io_sram_dq,
  output logic [4:0]    o_sram_control,
  output logic          o_busy
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int HB  = DW / 2;

  state_t         r_state;
  logic           r_sel_l;
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [1:0]     r_be;
  logic [WCW-1:0] r_wait;
  logic [4:0]     r_ctrl;
  logic           r_drive;
  logic           r_c_ack;
  logic           r_l_ack;
  logic [DW-1:0]  r_c_rdata;
  logic [DW-1:0]  r_l_rdata;
  logic           r_busy;

  logic w_grant_c;
  logic w_grant_l;
  logic w_update;
  logic w_win_we;
  logic [1:0] w_win_be;

  assign w_update = (r_state == ST_IDLE) && (i_c_req || i_l_req);
  assign w_win_we = w_grant_l ? i_l_we : i_c_we;
  assign w_win_be = w_grant_l ? i_l_be : i_c_be;

  sram_arbiter_rr u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_c_req   (i_c_req),
    .i_l_req   (i_l_req),
    .i_update  (w_update),
    .o_grant_c (w_grant_c),
    .o_grant_l (w_grant_l)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_sel_l   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= 2'b00;
      r_wait    <= '0;
      r_ctrl    <= CTRL_IDLE;
      r_drive   <= 1'b0;
      r_c_ack   <= 1'b0;
      r_l_ack   <= 1'b0;
      r_c_rdata <= '0;
      r_l_rdata <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_c_ack <= 1'b0;
      r_l_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_update) begin
            r_sel_l <= w_grant_l;
            r_we    <= w_win_we;
            r_addr  <= w_grant_l ? i_l_addr : i_c_addr;
            r_wdata <= w_grant_l ? i_l_wdata : i_c_wdata;
            r_be    <= w_win_be;
            r_wait  <= WCW'(WAIT_CYCLES - 1);
            r_ctrl  <= ctrl_access(w_win_we, w_win_be);
            r_drive <= w_win_we;
            r_busy  <= 1'b1;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_wait == '0) begin
            // Only enabled byte lanes are captured, so be=00 leaves rdata untouched.
            if (!r_we) begin
              if (r_sel_l) begin
                if (r_be[0]) r_l_rdata[HB-1:0]  <= io_sram_dq[HB-1:0];
                if (r_be[1]) r_l_rdata[DW-1:HB] <= io_sram_dq[DW-1:HB];
              end else begin
                if (r_be[0]) r_c_rdata[HB-1:0]  <= io_sram_dq[HB-1:0];
                if (r_be[1]) r_c_rdata[DW-1:HB] <= io_sram_dq[DW-1:HB];
              end
            end
            r_ctrl  <= CTRL_IDLE;
            r_drive <= 1'b0;
            r_c_ack <= ~r_sel_l;
            r_l_ack <= r_sel_l;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_sram_dq     = r_drive ? r_wdata : {DW{1'bz}};
  assign o_sram_addr    = r_addr;
  assign o_sram_control = r_ctrl;
  assign o_c_ack        = r_c_ack;
  assign o_l_ack        = r_l_ack;
  assign o_c_rdata      = r_c_rdata;
  assign o_l_rdata      = r_l_rdata;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed bench for sram_arbiter with 256Kx16 byte-lane SRAM models
// Instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=1.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;

  logic        c_req [2];
  logic        c_we [2];
  logic [17:0] c_addr [2];
  logic [15:0] c_wdata [2];
  logic [1:0]  c_be [2];
  logic [15:0] c_rdata [2];
  logic        c_ack [2];
  logic        l_req [2];
  logic        l_we [2];
  logic [17:0] l_addr [2];
  logic [15:0] l_wdata [2];
  logic [1:0]  l_be [2];
  logic [15:0] l_rdata [2];
  logic        l_ack [2];
  logic [17:0] saddr [2];
  logic [4:0]  ctrl [2];
  logic        busy [2];
  wire  [15:0] dq0;
  wire  [15:0] dq1;

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  always #30 clk = ~clk;

  sram_arbiter #(.AW(18), .DW(16), .WAIT_CYCLES(2)) dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_c_req(c_req[0]), .i_c_we(c_we[0]), .i_c_addr(c_addr[0]), .i_c_wdata(c_wdata[0]),
    .i_c_be(c_be[0]), .o_c_rdata(c_rdata[0]), .o_c_ack(c_ack[0]),
    .i_l_req(l_req[0]), .i_l_we(l_we[0]), .i_l_addr(l_addr[0]), .i_l_wdata(l_wdata[0]),
    .i_l_be(l_be[0]), .o_l_rdata(l_rdata[0]), .o_l_ack(l_ack[0]),
    .o_sram_addr(saddr[0]), .io_sram_dq(dq0), .o_sram_control(ctrl[0]), .o_busy(busy[0])
  );

  sram_arbiter #(.AW(18), .DW(16), .WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_c_req(c_req[1]), .i_c_we(c_we[1]), .i_c_addr(c_addr[1]), .i_c_wdata(c_wdata[1]),
    .i_c_be(c_be[1]), .o_c_rdata(c_rdata[1]), .o_c_ack(c_ack[1]),
    .i_l_req(l_req[1]), .i_l_we(l_we[1]), .i_l_addr(l_addr[1]), .i_l_wdata(l_wdata[1]),
    .i_l_be(l_be[1]), .o_l_rdata(l_rdata[1]), .o_l_ack(l_ack[1]),
    .o_sram_addr(saddr[1]), .io_sram_dq(dq1), .o_sram_control(ctrl[1]), .o_busy(busy[1])
  );

  // Async SRAM models: read drives the bus while CE_n=OE_n=0, WE_n=1; writes honour byte lanes.
  assign dq0 = (!ctrl[0][4] && !ctrl[0][3] && ctrl[0][2]) ? mem0[saddr[0]] : 16'hzzzz;
  assign dq1 = (!ctrl[1][4] && !ctrl[1][3] && ctrl[1][2]) ? mem1[saddr[1]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ctrl[0][4] && !ctrl[0][2]) begin
      if (!ctrl[0][0]) mem0[saddr[0]][7:0]  <= dq0[7:0];
      if (!ctrl[0][1]) mem0[saddr[0]][15:8] <= dq0[15:8];
    end
    if (!ctrl[1][4] && !ctrl[1][2]) begin
      if (!ctrl[1][0]) mem1[saddr[1]][7:0]  <= dq1[7:0];
      if (!ctrl[1][1]) mem1[saddr[1]][15:8] <= dq1[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input int k, input bit pl, input bit we, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        output int lat, output logic [4:0] c1, output logic [15:0] q1);
    @(negedge clk);
    if (pl) begin
      l_req[k] = 1'b1; l_we[k] = we; l_addr[k] = a; l_wdata[k] = d; l_be[k] = be;
    end else begin
      c_req[k] = 1'b1; c_we[k] = we; c_addr[k] = a; c_wdata[k] = d; c_be[k] = be;
    end
    lat = 99; c1 = '0; q1 = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        c1 = ctrl[k];
        q1 = (k == 0) ? dq0 : dq1;
      end
      if ((pl ? l_ack[k] : c_ack[k]) == 1'b1) begin
        lat = n;
        break;
      end
    end
    c_req[k] = 1'b0;
    l_req[k] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [4:0]  c1;
    logic [15:0] q1;
    logic [3:0]  order;
    logic [3:0]  exp_order;
    int          nack;
    bit          both;

    for (int k = 0; k < 2; k++) begin
      c_req[k] = 0; c_we[k] = 0; c_addr[k] = 0; c_wdata[k] = 0; c_be[k] = 0;
      l_req[k] = 0; l_we[k] = 0; l_addr[k] = 0; l_wdata[k] = 0; l_be[k] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'(ctrl[0]), 32'h1F);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_ack", 32'({c_ack[0], l_ack[0]}), 32'h0);
    chk("rst_rdata", 32'({c_rdata[0], l_rdata[0]}), 32'h0);
    chk("rst_addr", 32'(saddr[0]), 32'h0);
    chk("rst_dq_z", 32'(dq0 === 16'hzzzz), 32'h1);
    rst = 1'b0;

    // 1: C write 0xBEEF @0x10 be=11
    access(0, 0, 1, 18'h00010, 16'hBEEF, 2'b11, lat, c1, q1);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_ctrl", 32'(c1), 32'h08);
    chk("t1_dq", 32'(q1), 32'hBEEF);
    chk("t1_mem", 32'(mem0[18'h00010]), 32'hBEEF);

    // 2: C read back
    access(0, 0, 0, 18'h00010, 16'h0000, 2'b11, lat, c1, q1);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_ctrl", 32'(c1), 32'h04);
    chk("t2_rdata", 32'(c_rdata[0]), 32'hBEEF);
    chk("t2_done_dq_z", 32'(dq0 === 16'hzzzz), 32'h1);
    chk("t2_done_ctrl", 32'(ctrl[0]), 32'h1F);

    // 3: L low-byte write, then L read
    access(0, 1, 1, 18'h00010, 16'h1234, 2'b01, lat, c1, q1);
    chk("t3_wlat", 32'(lat), 32'd3);
    chk("t3_wctrl", 32'(c1), 32'h0A);
    chk("t3_mem", 32'(mem0[18'h00010]), 32'hBE34);
    access(0, 1, 0, 18'h00010, 16'h0000, 2'b11, lat, c1, q1);
    chk("t3_l_rdata", 32'(l_rdata[0]), 32'hBE34);
    chk("t3_c_rdata", 32'(c_rdata[0]), 32'hBEEF);

    // 4: simultaneous requests held for four accesses
    @(negedge clk);
    c_req[0] = 1; c_we[0] = 1; c_addr[0] = 18'h00030; c_wdata[0] = 16'h0C0C; c_be[0] = 2'b11;
    l_req[0] = 1; l_we[0] = 1; l_addr[0] = 18'h00031; l_wdata[0] = 16'h0A0A; l_be[0] = 2'b11;
    order = 4'b0; nack = 0; both = 0;
    for (int n = 0; n < 40 && nack < 4; n++) begin
      @(negedge clk);
      if (c_ack[0] && l_ack[0]) both = 1;
      if (c_ack[0] || l_ack[0]) begin
        order = {order[2:0], l_ack[0]};
        nack++;
      end
    end
    c_req[0] = 0; l_req[0] = 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b0101;
`endif
    chk("t4_nack", 32'(nack), 32'd4);
    chk("t4_order", 32'(order), 32'(exp_order));
    chk("t4_both_ack", 32'(both), 32'h0);
    chk("t4_mem_c", 32'(mem0[18'h00030]), 32'h0C0C);

    // 5: reset in the middle of ACCESS
    @(negedge clk);
    c_req[0] = 1; c_we[0] = 1; c_addr[0] = 18'h00010; c_wdata[0] = 16'h5555; c_be[0] = 2'b11;
    @(negedge clk);
    chk("t5_pre_ctrl", 32'(ctrl[0]), 32'h08);
    #5 rst = 1'b1;
    #1;
    chk("t5_ctrl", 32'(ctrl[0]), 32'h1F);
    chk("t5_busy", 32'(busy[0]), 32'h0);
    chk("t5_dq_z", 32'(dq0 === 16'hzzzz), 32'h1);
    chk("t5_ack", 32'(c_ack[0]), 32'h0);
    c_req[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_ack", 32'(c_ack[0]), 32'h0);
    chk("t5_mem", 32'(mem0[18'h00010]), 32'hBE34);
    access(0, 0, 0, 18'h00010, 16'h0000, 2'b11, lat, c1, q1);
    chk("t5_re_lat", 32'(lat), 32'd3);
    chk("t5_re_rdata", 32'(c_rdata[0]), 32'hBE34);

    // 6: WAIT_CYCLES=1 instance, be=00 accesses
    access(1, 0, 1, 18'h00005, 16'h1111, 2'b11, lat, c1, q1);
    chk("t6_w_lat", 32'(lat), 32'd2);
    access(1, 0, 1, 18'h00005, 16'hFFFF, 2'b00, lat, c1, q1);
    chk("t6_be0_lat", 32'(lat), 32'd2);
    chk("t6_be0_ctrl", 32'(c1), 32'h0B);
    chk("t6_be0_mem", 32'(mem1[18'h00005]), 32'h1111);
    access(1, 0, 0, 18'h00005, 16'h0000, 2'b11, lat, c1, q1);
    chk("t6_rdata", 32'(c_rdata[1]), 32'h1111);
    access(1, 0, 1, 18'h00006, 16'h2222, 2'b11, lat, c1, q1);
    access(1, 0, 0, 18'h00006, 16'h0000, 2'b00, lat, c1, q1);
    chk("t6_rbe0_lat", 32'(lat), 32'd2);
    chk("t6_rbe0_ctrl", 32'(c1), 32'h07);
    chk("t6_rbe0_rdata", 32'(c_rdata[1]), 32'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
